// File: rtl/div_clk_monitor_pkg.sv
// Shared state encodings, game-tick default divider and helpers for the divided-clock monitor.
// Combinational definitions only; no latency, no flow control.
package div_clk_monitor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MEASURE = 2'd1,
    ST_TRACK   = 2'd2,
    ST_LOCKED  = 2'd3
  } state_t;

  // Game tick is the /4 divider output.
  localparam int unsigned GAME_TICK_DIV = 4;

  function automatic int unsigned abs_diff(input int unsigned a, input int unsigned b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Three-flop synchronizer with rising-edge detect for asynchronous level inputs.
// rise is combinational from the 2nd/3rd flops (2-3 clk after d); no backpressure.
module sync_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic rise
);

  logic s1;
  logic s2;
  logic s3;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= d;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;

endmodule

// File: rtl/div_clk_monitor.sv
// Monitors a slow divided clock in the clk domain: tick per rise, period measure, lock/err FSM.
// tick registered 2 clk after div_in is first sampled high; outputs are free-running, no backpressure.
module div_clk_monitor
  import div_clk_monitor_pkg::*;
#(
  parameter int unsigned DIV_EXPECT = GAME_TICK_DIV,
  parameter int unsigned DIV_TOL    = 0,
  parameter int unsigned LOCK_COUNT = 4,
  parameter int unsigned TIMEOUT    = 16,
  parameter int unsigned CNT_W      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             div_in,
  output logic             tick,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             locked,
  output logic             err,
  output logic [1:0]       state
);

  localparam int unsigned      MCNT_W    = $clog2(LOCK_COUNT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [MCNT_W-1:0] LOCK_C   = MCNT_W'(LOCK_COUNT);

  logic              rise;
  logic [CNT_W-1:0]  cnt;
  logic              match;
  logic              timeout;
  logic [MCNT_W-1:0] mcnt_q;
  logic [MCNT_W-1:0] mcnt_d;
  logic [MCNT_W-1:0] mcnt_inc;
  state_t            state_q;
  state_t            state_d;
  logic [CNT_W-1:0]  period_d;
  logic              period_valid_d;
  logic              locked_d;
  logic              err_d;

  sync_edge_detect u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (div_in),
    .rise  (rise)
  );

  // Cycles since the last rise; saturation keeps a dead input from wrapping into a match.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (rise) begin
      cnt <= CNT_W'(1);
    end else if (cnt != CNT_MAX) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign match    = (abs_diff(32'(cnt), DIV_EXPECT) <= DIV_TOL);
  assign timeout  = (cnt == TIMEOUT_C) && !rise && (state_q != ST_IDLE);
  assign mcnt_inc = mcnt_q + MCNT_W'(1);

  always_comb begin
    state_d        = state_q;
    mcnt_d         = mcnt_q;
    period_d       = period;
    period_valid_d = 1'b0;
    locked_d       = locked;
    err_d          = 1'b0;

    if (rise) begin
      if (state_q == ST_IDLE) begin
        state_d = ST_MEASURE;
      end else begin
        period_d       = cnt;
        period_valid_d = 1'b1;
        if (match) begin
          case (state_q)
            ST_MEASURE: begin
              mcnt_d = MCNT_W'(1);
              if (LOCK_COUNT <= 1) begin
                state_d  = ST_LOCKED;
                locked_d = 1'b1;
              end else begin
                state_d = ST_TRACK;
              end
            end
            ST_TRACK: begin
              if (mcnt_inc >= LOCK_C) begin
                mcnt_d   = LOCK_C;
                state_d  = ST_LOCKED;
                locked_d = 1'b1;
              end else begin
                mcnt_d = mcnt_inc;
              end
            end
            default: begin
              mcnt_d = LOCK_C;
            end
          endcase
        end else begin
          // Any bad period restarts qualification from scratch.
          state_d  = ST_MEASURE;
          mcnt_d   = '0;
          locked_d = 1'b0;
          err_d    = 1'b1;
        end
      end
    end else if (timeout) begin
      state_d  = ST_IDLE;
      mcnt_d   = '0;
      locked_d = 1'b0;
      err_d    = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      mcnt_q       <= '0;
      tick         <= 1'b0;
      period       <= '0;
      period_valid <= 1'b0;
      locked       <= 1'b0;
      err          <= 1'b0;
    end else begin
      state_q      <= state_d;
      mcnt_q       <= mcnt_d;
      tick         <= rise;
      period       <= period_d;
      period_valid <= period_valid_d;
      locked       <= locked_d;
      err          <= err_d;
    end
  end

  assign state = state_q;

endmodule
